clock_rst_seq: RTL and testbench
================================

Name: clock_rst_seq

Overview:
- Parametrised successor to the single-MMCM lock synchroniser.
- Runs on the free-running input clock, so it keeps working even when generated clocks stop.
- Synchronises N lock signals from clock primitives and drives their reset pin with timed pulses and retry on timeout.
- Releases N_RST downstream domain resets in a fixed staggered order, and re-sequences from scratch on any lock loss.

Parameters:
- N_LOCK, 2, number of lock inputs (MMCM/PLL instances)
- SYNC_STAGES, 2, flip-flop stages per lock synchroniser (>=2)
- LOCK_HOLD, 16, cycles all synced locks must stay high before release begins (>=1)
- N_RST, 3, number of domain reset outputs
- RST_GAP, 8, cycles between successive reset releases (>=1)
- MMCM_RST_CYCLES, 4, width of each mmcm_rst pulse (>=1)
- LOCK_TIMEOUT, 65536, cycles allowed in lock wait before retry
- MAX_RETRY, 8, retries before fault; 0 = retry forever

Ports:
- clk_100m  in  1  free-running input clock
- rst  in  1  asynchronous, active-high reset
- locked_in  in  N_LOCK  raw lock flags, asynchronous to clk_100m
- mmcm_rst  out  1  reset to all clock primitives, active-high
- rst_out  out  N_RST  domain resets, active-high, synchronous deassert to clk_100m
- all_locked  out  1  high when every lock is good and every rst_out is released
- retry_count  out  8  retries since rst, saturates at 255
- fault  out  1  retry limit reached

Behaviour:
- All outputs are registered.
- Reset values: mmcm_rst=1, rst_out=all 1, all_locked=0, retry_count=0, fault=0, state=S_PLLRST.
- Asynchronous rst forces reset values immediately, in any state.
- Synchroniser: each locked_in bit passes through SYNC_STAGES flops. lk_ok = AND of the synced bits.
- S_PLLRST:
  - mmcm_rst=1 for exactly MMCM_RST_CYCLES cycles, then -> S_WAIT_LOCK.
  - Counts from the first clock edge after rst falls.
- S_WAIT_LOCK:
  - mmcm_rst=0. hold_cnt increments while lk_ok=1 and clears on any cycle with lk_ok=0.
  - When hold_cnt reaches LOCK_HOLD -> S_RELEASE.
  - tmo_cnt counts from state entry. At LOCK_TIMEOUT without release: if MAX_RETRY!=0 and retry_count+1==MAX_RETRY -> S_FAULT, else retry_count++ and -> S_PLLRST.
- S_RELEASE:
  - rst_out[0] deasserts first. rst_out[i] deasserts RST_GAP cycles after rst_out[i-1].
  - RST_GAP cycles after rst_out[N_RST-1] deasserts -> S_RUN.
- S_RUN: all_locked=1.
- Lock loss in S_RELEASE or S_RUN (lk_ok=0):
  - rst_out=all 1 and all_locked=0 on the next registered update.
  - retry_count++ (saturating), then -> S_PLLRST, or -> S_FAULT per the MAX_RETRY rule.
- S_FAULT: mmcm_rst=0, rst_out=all 1, all_locked=0, fault=1. Terminal until rst.
- Timing, measured from the first edge sampling locked_in all high:
  - rst_out[0] falls SYNC_STAGES+LOCK_HOLD cycles later.
  - all_locked rises SYNC_STAGES+LOCK_HOLD+N_RST*RST_GAP cycles later.
- Timing from the edge sampling any locked_in low, in RELEASE/RUN: rst_out=all 1 after SYNC_STAGES+1 cycles.
- Simultaneous events:
  - Lock loss on the same cycle as a stagger step: lock loss wins.
  - Timeout on the same cycle hold completes: release wins.
- Counter widths are $clog2 of their max plus 1. No wrap is permitted except retry_count saturation.

Decomposition:
- Package clock_sys_pkg:
  - state enum {S_PLLRST, S_WAIT_LOCK, S_RELEASE, S_RUN, S_FAULT}
  - counter-width helper function
  - retry_count width constant (8)
- Sub-module sync_bits #(WIDTH, STAGES): multi-bit per-bit flop synchroniser with async reset to 0. Instantiated once, WIDTH=N_LOCK.

Test Plan:
(Bench params: N_LOCK=2, SYNC_STAGES=2, LOCK_HOLD=4, N_RST=3, RST_GAP=2, MMCM_RST_CYCLES=3, LOCK_TIMEOUT=20, MAX_RETRY=2.)
1. Reset release -> mmcm_rst high for exactly 3 edges then 0; rst_out=3'b111, all_locked=0, retry_count=0, fault=0.
2. Both locks rise, first sampled at edge E -> rst_out[0] falls at E+6, rst_out[1] at E+8, rst_out[2] at E+10; all_locked=1 at E+12.
3. Glitch: locked_in[1] low for one cycle at E+3 -> hold restarts; rst_out[0] falls at E+10; retry_count stays 0.
4. In S_RUN, locked_in[0] falls at edge F -> rst_out=3'b111, all_locked=0 at F+3; mmcm_rst pulses 3 cycles; retry_count=1; relock sequence repeats with the test-2 timing.
5. Locks never assert -> timeout at 20 cycles, retry_count=1, second mmcm_rst pulse; next timeout -> fault=1, mmcm_rst=0, rst_out=3'b111, held 100 cycles until rst.
6. Async rst asserted mid-S_RELEASE, between clock edges -> all outputs take reset values before the next edge; normal sequence resumes after rst falls.

Source files
------------

// File: rtl/clock_sys_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clock_sys_pkg
//  Purpose  : Shared types and helpers for the clock/reset sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package clock_sys_pkg;

  // Width of the retry counter output (saturates at all ones).
  localparam int RETRY_W = 8;

  // Sequencer states.
  typedef enum logic [2:0] {
    S_PLLRST    = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_RELEASE   = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  // Bits needed for a counter that must hold values up to max_val.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_bits.sv
`default_nettype none
// ============================================================================
//  Module   : sync_bits
//  Purpose  : Per-bit multi-flop synchroniser, asynchronous reset to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_bits #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Index 0 is the first (metastable-capture) stage.
  logic [STAGES-1:0][WIDTH-1:0] r_stage;

  // Shift each input bit through STAGES flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[STAGES-2:0], d};
    end
  end

  assign q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/clock_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : clock_rst_seq
//  Purpose  : Clock primitive reset / lock sequencer with staggered domain
//             reset release, timeout retry and fault latch.
//  Revision : 1.0 - initial release
// ============================================================================
module clock_rst_seq
  import clock_sys_pkg::*;
#(
  parameter int N_LOCK          = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int LOCK_HOLD       = 16,
  parameter int N_RST           = 3,
  parameter int RST_GAP         = 8,
  parameter int MMCM_RST_CYCLES = 4,
  parameter int LOCK_TIMEOUT    = 65536,
  parameter int MAX_RETRY       = 8
) (
  input  logic               clk_100m,
  input  logic               rst,
  input  logic [N_LOCK-1:0]  locked_in,
  output logic               mmcm_rst,
  output logic [N_RST-1:0]   rst_out,
  output logic               all_locked,
  output logic [RETRY_W-1:0] retry_count,
  output logic               fault
);

  localparam int PW = cnt_w(MMCM_RST_CYCLES);
  localparam int HW = cnt_w(LOCK_HOLD);
  localparam int TW = cnt_w(LOCK_TIMEOUT);
  localparam int GW = cnt_w(RST_GAP);

  localparam logic [PW-1:0]    PLS_LAST = PW'(MMCM_RST_CYCLES - 1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(LOCK_HOLD - 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [GW-1:0]    GAP_LAST = GW'(RST_GAP - 1);
  localparam logic [N_RST-1:0] RST_ALL = {N_RST{1'b1}};

  logic [N_LOCK-1:0]  w_lk_sync;
  logic               r_lk_ok;

  state_t             r_state,  w_state;
  logic [PW-1:0]      r_pcnt,   w_pcnt;
  logic [HW-1:0]      r_hold,   w_hold;
  logic [TW-1:0]      r_tmo,    w_tmo;
  logic [GW-1:0]      r_gap,    w_gap;
  logic               r_mmcm,   w_mmcm;
  logic [N_RST-1:0]   r_rst,    w_rst;
  logic               r_all,    w_all;
  logic [RETRY_W-1:0] r_retry,  w_retry;
  logic               r_fault,  w_fault;

  logic               w_retry_hit;
  logic [RETRY_W-1:0] w_retry_inc;

  sync_bits #(
    .WIDTH  (N_LOCK),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk_100m),
    .rst (rst),
    .d   (locked_in),
    .q   (w_lk_sync)
  );

  // Register the combined lock flag so a single flop feeds the FSM; this
  // adds one cycle to both lock-acquire and lock-loss reaction.
  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) r_lk_ok <= 1'b0;
    else     r_lk_ok <= &w_lk_sync;
  end

  // The next failure either exhausts the retry budget or bumps the counter.
  assign w_retry_hit = (MAX_RETRY != 0) && ((int'(r_retry) + 1) == MAX_RETRY);
  assign w_retry_inc = (r_retry == {RETRY_W{1'b1}}) ? r_retry : r_retry + RETRY_W'(1);

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    w_state = r_state;
    w_pcnt  = r_pcnt;
    w_hold  = r_hold;
    w_tmo   = r_tmo;
    w_gap   = r_gap;
    w_mmcm  = r_mmcm;
    w_rst   = r_rst;
    w_all   = r_all;
    w_retry = r_retry;
    w_fault = r_fault;

    case (r_state)
      S_PLLRST: begin
        w_rst  = RST_ALL;
        w_all  = 1'b0;
        w_hold = '0;
        w_tmo  = '0;
        if (r_pcnt == PLS_LAST) begin
          w_state = S_WAIT_LOCK;
          w_mmcm  = 1'b0;
          w_pcnt  = '0;
        end else begin
          w_mmcm  = 1'b1;
          w_pcnt  = r_pcnt + PW'(1);
        end
      end

      S_WAIT_LOCK: begin
        w_mmcm = 1'b0;
        // Completing the hold takes priority over a coincident timeout.
        if (r_lk_ok && (r_hold == HOLD_LAST)) begin
          w_state = S_RELEASE;
          w_rst   = RST_ALL << 1;
          w_gap   = '0;
          w_hold  = '0;
          w_tmo   = '0;
        end else if (r_tmo == TMO_LAST) begin
          w_hold = '0;
          w_tmo  = '0;
          if (w_retry_hit) begin
            w_state = S_FAULT;
            w_fault = 1'b1;
          end else begin
            w_state = S_PLLRST;
            w_retry = w_retry_inc;
            w_mmcm  = 1'b1;
            w_pcnt  = '0;
          end
        end else begin
          w_tmo  = r_tmo + TW'(1);
          w_hold = r_lk_ok ? r_hold + HW'(1) : '0;
        end
      end

      S_RELEASE, S_RUN: begin
        if (!r_lk_ok) begin
          // Lock loss overrides any pending stagger step.
          w_rst = RST_ALL;
          w_all = 1'b0;
          w_gap = '0;
          if (w_retry_hit) begin
            w_state = S_FAULT;
            w_fault = 1'b1;
            w_mmcm  = 1'b0;
          end else begin
            w_state = S_PLLRST;
            w_retry = w_retry_inc;
            w_mmcm  = 1'b1;
            w_pcnt  = '0;
          end
        end else if (r_state == S_RELEASE) begin
          if (r_gap == GAP_LAST) begin
            w_gap = '0;
            if (r_rst == '0) begin
              w_state = S_RUN;
              w_all   = 1'b1;
            end else begin
              w_rst = r_rst << 1;
            end
          end else begin
            w_gap = r_gap + GW'(1);
          end
        end
      end

      S_FAULT: begin
        w_mmcm  = 1'b0;
        w_rst   = RST_ALL;
        w_all   = 1'b0;
        w_fault = 1'b1;
      end

      default: begin
        w_state = S_PLLRST;
        w_mmcm  = 1'b1;
        w_rst   = RST_ALL;
        w_all   = 1'b0;
        w_pcnt  = '0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      r_state <= S_PLLRST;
      r_pcnt  <= '0;
      r_hold  <= '0;
      r_tmo   <= '0;
      r_gap   <= '0;
      r_mmcm  <= 1'b1;
      r_rst   <= RST_ALL;
      r_all   <= 1'b0;
      r_retry <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pcnt  <= w_pcnt;
      r_hold  <= w_hold;
      r_tmo   <= w_tmo;
      r_gap   <= w_gap;
      r_mmcm  <= w_mmcm;
      r_rst   <= w_rst;
      r_all   <= w_all;
      r_retry <= w_retry;
      r_fault <= w_fault;
    end
  end

  assign mmcm_rst    = r_mmcm;
  assign rst_out     = r_rst;
  assign all_locked  = r_all;
  assign retry_count = r_retry;
  assign fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_clock_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_rst_seq
//  Purpose  : Directed self-checking bench for clock_rst_seq using a
//             cycle-stamped expectation queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clock_rst_seq;

  logic       clk_100m = 1'b0;
  logic       rst;
  logic [1:0] locked_in;
  logic       mmcm_rst;
  logic [2:0] rst_out;
  logic       all_locked;
  logic [7:0] retry_count;
  logic       fault;

  always #5 clk_100m = ~clk_100m;

  clock_rst_seq #(
    .N_LOCK          (2),
    .SYNC_STAGES     (2),
    .LOCK_HOLD       (4),
    .N_RST           (3),
    .RST_GAP         (2),
    .MMCM_RST_CYCLES (3),
    .LOCK_TIMEOUT    (20),
    .MAX_RETRY       (2)
  ) dut (
    .clk_100m    (clk_100m),
    .rst         (rst),
    .locked_in   (locked_in),
    .mmcm_rst    (mmcm_rst),
    .rst_out     (rst_out),
    .all_locked  (all_locked),
    .retry_count (retry_count),
    .fault       (fault)
  );

  // Observed snapshot: {mmcm_rst, rst_out, all_locked, retry_count, fault}.
  logic [13:0] obs;
  assign obs = {mmcm_rst, rst_out, all_locked, retry_count, fault};

  typedef struct {
    int          cyc;
    string       tag;
    logic [13:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [13:0] s(input logic mm, input logic [2:0] ro,
                                    input logic al, input logic [7:0] rc,
                                    input logic ft);
    return {mm, ro, al, rc, ft};
  endfunction

  task automatic expect_at(input int c, input string tag, input logic [13:0] v);
    exp_t e;
    e.cyc = c;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_now(input string tag, input logic [13:0] v);
    n_checks++;
    assert (obs === v) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, v);
    end
  endtask

  // Advance one edge, sample 1 ns later, retire expectations due now.
  task automatic tick();
    @(posedge clk_100m);
    #1;
    cyc++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        n_checks++;
        assert (obs === sb[i].val) else begin
          n_fail++;
          $error("FAIL %s cyc=%0d observed=%h expected=%h",
                 sb[i].tag, cyc, obs, sb[i].val);
        end
        sb.delete(i);
      end
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  int c0, e, f, e2, r0, r1, r2;

  initial begin
    rst       = 1'b1;
    locked_in = 2'b00;
    tick();
    tick();
    check_now("reset_values", s(1'b1, 3'b111, 1'b0, 8'd0, 1'b0));

    // Reset release: mmcm_rst pulse of three edges
    rst = 1'b0;
    c0  = cyc;
    expect_at(c0 + 1, "t1_mm_e1", s(1'b1, 3'b111, 1'b0, 8'd0, 1'b0));
    expect_at(c0 + 2, "t1_mm_e2", s(1'b1, 3'b111, 1'b0, 8'd0, 1'b0));
    expect_at(c0 + 3, "t1_mm_low", s(1'b0, 3'b111, 1'b0, 8'd0, 1'b0));
    run_to(c0 + 3);

    // Both locks rise: staggered release then all_locked
    locked_in = 2'b11;
    e = cyc + 1;
    expect_at(e + 5,  "t2_pre_r0", s(1'b0, 3'b111, 1'b0, 8'd0, 1'b0));
    expect_at(e + 6,  "t2_r0",     s(1'b0, 3'b110, 1'b0, 8'd0, 1'b0));
    expect_at(e + 7,  "t2_pre_r1", s(1'b0, 3'b110, 1'b0, 8'd0, 1'b0));
    expect_at(e + 8,  "t2_r1",     s(1'b0, 3'b100, 1'b0, 8'd0, 1'b0));
    expect_at(e + 10, "t2_r2",     s(1'b0, 3'b000, 1'b0, 8'd0, 1'b0));
    expect_at(e + 11, "t2_pre_al", s(1'b0, 3'b000, 1'b0, 8'd0, 1'b0));
    expect_at(e + 12, "t2_al",     s(1'b0, 3'b000, 1'b1, 8'd0, 1'b0));
    expect_at(e + 15, "t2_run",    s(1'b0, 3'b000, 1'b1, 8'd0, 1'b0));
    run_to(e + 15);

    // Lock loss in RUN, retry pulse, relock
    locked_in = 2'b10;
    f = cyc + 1;
    expect_at(f + 2, "t4_pre_loss", s(1'b0, 3'b000, 1'b1, 8'd0, 1'b0));
    expect_at(f + 3, "t4_loss",     s(1'b1, 3'b111, 1'b0, 8'd1, 1'b0));
    expect_at(f + 5, "t4_pulse",    s(1'b1, 3'b111, 1'b0, 8'd1, 1'b0));
    expect_at(f + 6, "t4_pulse_end", s(1'b0, 3'b111, 1'b0, 8'd1, 1'b0));
    run_to(f + 6);
    locked_in = 2'b11;
    e2 = cyc + 1;
    expect_at(e2 + 5, "t4_re_pre_r0", s(1'b0, 3'b111, 1'b0, 8'd1, 1'b0));
    expect_at(e2 + 6, "t4_re_r0",     s(1'b0, 3'b110, 1'b0, 8'd1, 1'b0));
    expect_at(e2 + 8, "t4_re_r1",     s(1'b0, 3'b100, 1'b0, 8'd1, 1'b0));
    run_to(e2 + 8);

    // Asynchronous reset between edges in RELEASE
    #3;
    rst = 1'b1;
    #1;
    check_now("t6_async", s(1'b1, 3'b111, 1'b0, 8'd0, 1'b0));
    tick();
    check_now("t6_held", s(1'b1, 3'b111, 1'b0, 8'd0, 1'b0));
    rst = 1'b0;
    r0  = cyc;
    expect_at(r0 + 2,  "t6_mm",     s(1'b1, 3'b111, 1'b0, 8'd0, 1'b0));
    expect_at(r0 + 3,  "t6_mm_low", s(1'b0, 3'b111, 1'b0, 8'd0, 1'b0));
    expect_at(r0 + 6,  "t6_pre_r0", s(1'b0, 3'b111, 1'b0, 8'd0, 1'b0));
    expect_at(r0 + 7,  "t6_r0",     s(1'b0, 3'b110, 1'b0, 8'd0, 1'b0));
    expect_at(r0 + 12, "t6_pre_al", s(1'b0, 3'b000, 1'b0, 8'd0, 1'b0));
    expect_at(r0 + 13, "t6_al",     s(1'b0, 3'b000, 1'b1, 8'd0, 1'b0));
    run_to(r0 + 13);

    // One-cycle glitch on locked_in[1] restarts the hold
    rst       = 1'b1;
    locked_in = 2'b00;
    tick();
    rst = 1'b0;
    r1  = cyc;
    run_to(r1 + 3);
    locked_in = 2'b11;
    e = cyc + 1;
    expect_at(e + 6,  "t3_no_early", s(1'b0, 3'b111, 1'b0, 8'd0, 1'b0));
    expect_at(e + 9,  "t3_pre_r0",   s(1'b0, 3'b111, 1'b0, 8'd0, 1'b0));
    expect_at(e + 10, "t3_r0",       s(1'b0, 3'b110, 1'b0, 8'd0, 1'b0));
    expect_at(e + 16, "t3_al",       s(1'b0, 3'b000, 1'b1, 8'd0, 1'b0));
    run_to(e + 2);
    locked_in = 2'b01;
    run_to(e + 3);
    locked_in = 2'b11;
    run_to(e + 16);

    // Locks never assert: two timeouts lead to fault
    rst       = 1'b1;
    locked_in = 2'b00;
    tick();
    rst = 1'b0;
    r2  = cyc;
    expect_at(r2 + 3,   "t5_wait",      s(1'b0, 3'b111, 1'b0, 8'd0, 1'b0));
    expect_at(r2 + 22,  "t5_pre_tmo1",  s(1'b0, 3'b111, 1'b0, 8'd0, 1'b0));
    expect_at(r2 + 23,  "t5_tmo1",      s(1'b1, 3'b111, 1'b0, 8'd1, 1'b0));
    expect_at(r2 + 25,  "t5_pulse2",    s(1'b1, 3'b111, 1'b0, 8'd1, 1'b0));
    expect_at(r2 + 26,  "t5_pulse2_end", s(1'b0, 3'b111, 1'b0, 8'd1, 1'b0));
    expect_at(r2 + 45,  "t5_pre_fault", s(1'b0, 3'b111, 1'b0, 8'd1, 1'b0));
    expect_at(r2 + 46,  "t5_fault",     s(1'b0, 3'b111, 1'b0, 8'd1, 1'b1));
    expect_at(r2 + 100, "t5_fault_mid", s(1'b0, 3'b111, 1'b0, 8'd1, 1'b1));
    expect_at(r2 + 146, "t5_fault_end", s(1'b0, 3'b111, 1'b0, 8'd1, 1'b1));
    run_to(r2 + 60);
    locked_in = 2'b11;
    run_to(r2 + 146);
    rst = 1'b1;
    #1;
    check_now("t5_rst_clear", s(1'b1, 3'b111, 1'b0, 8'd0, 1'b0));

    // Any expectation never reached counts as a failure
    while (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s never checked (due cyc=%0d, now %0d)", sb[0].tag, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
